frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 124 ++++++++++++
 tb/tb_frame_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame counter sequencer: advances a frame number on VSync ticks with
// run/pause, single-step, direction and speed control, plus a fading trail length.
module frame_sequencer #(
  parameter int unsigned FRAME_BITS  = 9,
  parameter int unsigned MAX_PERSIST = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  run,
  input  logic                  step,
  input  logic                  dir,
  input  logic [2:0]            speed,
  output logic [FRAME_BITS-1:0] frame_no,
  output logic [3:0]            persist_len,
  output logic                  frame_tick,
  output logic                  paused
);

  typedef enum logic {RUN, PAUSE} state_t;

  state_t                state, state_next;
  logic                  run_m, run_s;
  logic                  step_m, step_s, step_d;
  logic                  dir_m, dir_s;
  logic [2:0]            speed_m, speed_s;
  logic                  prev_vsync;
  logic [2:0]            div_cnt, div_next;
  logic                  step_pending, pend_next;
  logic [FRAME_BITS-1:0] frame_next;
  logic [3:0]            persist_next;
  logic                  step_rise;
  logic                  advance;

  assign step_rise = step_s & ~step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_m        <= 1'b0;
      run_s        <= 1'b0;
      step_m       <= 1'b0;
      step_s       <= 1'b0;
      step_d       <= 1'b0;
      dir_m        <= 1'b0;
      dir_s        <= 1'b0;
      speed_m      <= '0;
      speed_s      <= '0;
      prev_vsync   <= 1'b1;
      frame_tick   <= 1'b0;
      state        <= RUN;
      frame_no     <= '0;
      persist_len  <= 4'(MAX_PERSIST);
      div_cnt      <= '0;
      step_pending <= 1'b0;
      paused       <= 1'b0;
    end else begin
      run_m        <= run;
      run_s        <= run_m;
      step_m       <= step;
      step_s       <= step_m;
      step_d       <= step_s;
      dir_m        <= dir;
      dir_s        <= dir_m;
      speed_m      <= speed;
      speed_s      <= speed_m;
      prev_vsync   <= vsync;
      frame_tick   <= vsync & ~prev_vsync;
      state        <= state_next;
      frame_no     <= frame_next;
      persist_len  <= persist_next;
      div_cnt      <= div_next;
      step_pending <= pend_next;
      paused       <= (state_next == PAUSE);
    end
  end

  always_comb begin
    state_next   = state;
    persist_next = persist_len;
    div_next     = div_cnt;
    pend_next    = step_pending;
    advance      = 1'b0;

    // Only one step per tick: a flag, so extra edges before the tick collapse.
    if (state == PAUSE && step_rise)
      pend_next = 1'b1;

    if (frame_tick) begin
      unique case (state)
        RUN: begin
          if (!run_s) begin
            state_next = PAUSE;
          end else if (div_cnt >= speed_s) begin
            // >= so that lowering speed below div_cnt advances immediately
            advance  = 1'b1;
            div_next = '0;
          end else begin
            div_next = div_cnt + 3'd1;
          end
        end
        PAUSE: begin
          if (run_s) begin
            state_next   = RUN;
            div_next     = '0;
            persist_next = 4'(MAX_PERSIST);
            pend_next    = 1'b0;
          end else if (step_pending || step_rise) begin
            advance      = 1'b1;
            pend_next    = 1'b0;
            persist_next = 4'd1;
          end else if (persist_len != 4'd0) begin
            persist_next = persist_len - 4'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end

    frame_next = frame_no;
    if (advance)
      frame_next = dir_s ? frame_no - FRAME_BITS'(1) : frame_no + FRAME_BITS'(1);
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer.
module tb_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       run;
  logic       step;
  logic       dir;
  logic [2:0] speed;
  logic [8:0] frame_no;
  logic [3:0] persist_len;
  logic       frame_tick;
  logic       paused;

  int unsigned tests  = 0;
  int unsigned fails  = 0;
  int unsigned ticks  = 0;
  int unsigned t0;

  frame_sequencer #(.FRAME_BITS(9), .MAX_PERSIST(14)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .run         (run),
    .step        (step),
    .dir         (dir),
    .speed       (speed),
    .frame_no    (frame_no),
    .persist_len (persist_len),
    .frame_tick  (frame_tick),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick) ticks++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lets inputs cross the synchronizers, then one vsync rising edge.
  task automatic frame();
    idle(4);
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(4);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    idle(4);
    step = 1'b0;
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; run = 1'b1; step = 1'b0; dir = 1'b0; speed = 3'd0;
    idle(3);
    check("rst_frame", frame_no, 0);
    check("rst_persist", persist_len, 14);
    check("rst_paused", paused, 0);
    check("rst_tick", frame_tick, 0);
    rst_n = 1'b1;
    idle(4);

    // Free run, speed 0
    repeat (3) frame();
    check("run3_frame", frame_no, 3);
    check("run3_ticks", ticks, 3);

    // speed 2: advance every third tick
    speed = 3'd2;
    repeat (3) frame();
    check("spd2_3", frame_no, 4);
    repeat (3) frame();
    check("spd2_6", frame_no, 5);

    // Count down to zero then wrap below
    speed = 3'd0; dir = 1'b1;
    repeat (5) frame();
    check("down_zero", frame_no, 0);
    frame();
    check("wrap_down", frame_no, 9'h1FF);
    dir = 1'b0;
    frame();
    check("wrap_up", frame_no, 0);

    // Lowering speed below div_cnt forces an immediate advance
    speed = 3'd5;
    repeat (3) frame();
    check("spd5_hold", frame_no, 0);
    speed = 3'd1;
    frame();
    check("spd_lower", frame_no, 1);
    frame();
    check("spd1_wait", frame_no, 1);
    frame();
    check("spd1_adv", frame_no, 2);

    // Pause: first tick only changes state, later ticks fade trails
    speed = 3'd0; run = 1'b0;
    frame();
    check("pause_paused", paused, 1);
    check("pause_frame", frame_no, 2);
    check("pause_p14", persist_len, 14);
    frame();
    check("pause_p13", persist_len, 13);
    frame();
    check("pause_p12", persist_len, 12);
    frame();
    check("pause_p11", persist_len, 11);
    check("pause_frame4", frame_no, 2);

    step_pulse();
    frame();
    check("step_frame", frame_no, 3);
    check("step_persist", persist_len, 1);

    // Several step pulses collapse into one advance
    repeat (3) step_pulse();
    frame();
    check("multi_step", frame_no, 4);
    frame();
    check("fade_p0", persist_len, 0);
    frame();
    check("fade_sat", persist_len, 0);
    check("fade_frame", frame_no, 4);

    // Step edge reaching the core in the same cycle as frame_tick
    step = 1'b1;
    idle(1);
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0; step = 1'b0;
    idle(1);
    check("same_cyc_step", frame_no, 5);
    idle(3);

    // Resume: no advance on the resume tick, trails restored
    run = 1'b1;
    frame();
    check("resume_paused", paused, 0);
    check("resume_frame", frame_no, 5);
    check("resume_persist", persist_len, 14);
    frame();
    check("resume_adv", frame_no, 6);

    // Reset mid-frame while paused with a step pending
    run = 1'b0;
    frame();
    check("pause2", paused, 1);
    step_pulse();
    vsync = 1'b1;
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_frame", frame_no, 0);
    check("arst_persist", persist_len, 14);
    check("arst_paused", paused, 0);
    check("arst_tick", frame_tick, 0);
    vsync = 1'b0; run = 1'b1;
    idle(2);
    rst_n = 1'b1;
    t0 = ticks;
    frame();
    check("post_rst_ticks", ticks - t0, 1);
    check("post_rst_frame", frame_no, 1);
    check("post_rst_paused", paused, 0);

    // Reset released with vsync already high
    vsync = 1'b1;
    idle(1);
    rst_n = 1'b0;
    idle(2);
    t0 = ticks;
    rst_n = 1'b1;
    idle(6);
    check("vhigh_no_tick", ticks - t0, 0);
    check("vhigh_frame", frame_no, 0);
    vsync = 1'b0;
    frame();
    check("vhigh_tick", ticks - t0, 1);
    check("vhigh_adv", frame_no, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
